// File: rtl/aqp_esp_uart_txq_if.sv
// Bus between the CPU-side register logic, the ESP UART transmitter and the TX queue.
// The master drives writes and UART status; the slave (the queue) drives status and TX strobes.
interface aqp_esp_uart_txq_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          wrdata;
   logic                wr_en;
   logic                flush;
   logic                brk_req;
   logic                full;
   logic                empty;
   logic [DEPTH_LOG2:0] free_count;
   logic                overflow;
   logic                brk_active;
   logic                uart_cts;
   logic [7:0]          tx_data;
   logic                tx_valid;
   logic                tx_break;
   logic                tx_busy;

   modport master (
      output wrdata, wr_en, flush, brk_req, uart_cts, tx_busy,
      input  full, empty, free_count, overflow, brk_active, tx_data, tx_valid, tx_break
   );

   modport slave (
      input  wrdata, wr_en, flush, brk_req, uart_cts, tx_busy,
      output full, empty, free_count, overflow, brk_active, tx_data, tx_valid, tx_break
   );
endinterface

// File: rtl/aqp_esp_uart_txq.sv
// ESP UART transmit queue: byte FIFO drained into the UART TX strobe interface, with break sequencing.
// Define ESP_TXQ_CTS_EN to gate launches on the synchronised CTS pin.
module aqp_esp_uart_txq #(
   parameter int DEPTH_LOG2 = 4,
   parameter int BREAK_CLKS = 25000
) (
   input logic                 clk,
   input logic                 reset,
   aqp_esp_uart_txq_if.slave   bus
);
   localparam int                  DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
   localparam int                  BW = $clog2(BREAK_CLKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_BREAK} state_t;

   state_t              state, state_nxt;
   logic [7:0]          mem [DEPTH];
   logic [DEPTH_LOG2:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
   logic [DEPTH_LOG2:0] free_count;
   logic                full, empty, overflow;
   logic [7:0]          tx_data;
   logic                tx_valid, tx_break, brk_pend;
   logic [BW-1:0]       brk_cnt;
   logic                wr_ok, pop, brk_start, brk_done, cts_stop;

`ifdef ESP_TXQ_CTS_EN
   logic [1:0] cts_sync;

   // Resets to "stop" so nothing launches until the pin has been seen low twice.
   always_ff @(posedge clk) begin
      if (!reset) cts_sync <= 2'b11;
      else        cts_sync <= {cts_sync[0], bus.uart_cts};
   end
   assign cts_stop = cts_sync[1];
`else
   logic cts_unused;
   assign cts_unused = bus.uart_cts;
   assign cts_stop   = 1'b0;
`endif

   // FIFO pointer arithmetic; flush wins over a same-cycle write.
   assign wr_ok     = bus.wr_en && !full && !bus.flush;
   assign wptr_nxt  = wptr + (DEPTH_LOG2+1)'(wr_ok);
   assign rptr_nxt  = bus.flush ? wptr : rptr + (DEPTH_LOG2+1)'(pop);
   assign count_nxt = wptr_nxt - rptr_nxt;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr[DEPTH_LOG2-1:0]] <= bus.wrdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pop)            state_nxt = S_LAUNCH;
                   else if (brk_start) state_nxt = S_BREAK;
         S_LAUNCH:                     state_nxt = S_WAIT;
         S_WAIT:   if (!bus.tx_busy)   state_nxt = S_IDLE;
         S_BREAK:  if (brk_done)       state_nxt = S_IDLE;
         default:                      state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pop       = 1'b0;
      brk_start = 1'b0;
      brk_done  = 1'b0;
      case (state)
         S_IDLE: begin
            pop       = !empty && !bus.tx_busy && !cts_stop;
            brk_start = !pop && brk_pend && empty && !bus.tx_busy;
         end
         S_BREAK: brk_done = (brk_cnt == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr       <= '0;
         rptr       <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         free_count <= DEPTH_V;
         overflow   <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         tx_break   <= 1'b0;
         brk_pend   <= 1'b0;
         brk_cnt    <= '0;
      end else begin
         wptr       <= wptr_nxt;
         rptr       <= rptr_nxt;
         full       <= (count_nxt == DEPTH_V);
         empty      <= (count_nxt == '0);
         free_count <= DEPTH_V - count_nxt;
         overflow   <= bus.wr_en && full && !bus.flush;
         tx_valid   <= pop;
         if (pop) tx_data <= mem[rptr[DEPTH_LOG2-1:0]];
         // Break length counts BREAK_CLKS cycles starting with the entry edge.
         if (brk_start) begin
            tx_break <= 1'b1;
            brk_cnt  <= BW'(BREAK_CLKS - 1);
         end else if (brk_done) begin
            tx_break <= 1'b0;
         end else if (state == S_BREAK) begin
            brk_cnt  <= brk_cnt - 1'b1;
         end
         if (brk_done)         brk_pend <= 1'b0;
         else if (bus.brk_req) brk_pend <= 1'b1;
      end
   end

   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.free_count = free_count;
   assign bus.overflow   = overflow;
   assign bus.brk_active = brk_pend;
   assign bus.tx_data    = tx_data;
   assign bus.tx_valid   = tx_valid;
   assign bus.tx_break   = tx_break;
endmodule

// File: tb/tb_aqp_esp_uart_txq.sv
// Scoreboard bench for aqp_esp_uart_txq: expected TX bytes are queued at write time and
// checked by a monitor on every tx_valid; a small UART model supplies tx_busy.
module tb_aqp_esp_uart_txq;
   localparam int DL    = 4;
   localparam int BC    = 20;
   localparam int FRAME = 10;

   logic clk = 1'b0;
   logic reset;
   logic uart_busy;
   logic hold_busy;
   int   frame_cnt;
   int   checks = 0;
   int   errors = 0;
   int   tx_cnt = 0;
   logic [7:0] exp_q [$];

   aqp_esp_uart_txq_if #(.DEPTH_LOG2(DL)) bus ();

   aqp_esp_uart_txq #(.DEPTH_LOG2(DL), .BREAK_CLKS(BC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.tx_busy = uart_busy | hold_busy;

   // UART TX model: busy from the edge after the start strobe for FRAME cycles.
   always @(posedge clk) begin
      if (!reset) begin
         uart_busy <= 1'b0;
         frame_cnt <= 0;
      end else if (bus.tx_valid) begin
         uart_busy <= 1'b1;
         frame_cnt <= FRAME;
      end else if (frame_cnt > 0) begin
         frame_cnt <= frame_cnt - 1;
         if (frame_cnt == 1) uart_busy <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit expect_tx);
      bus.wrdata = d;
      bus.wr_en  = 1'b1;
      if (expect_tx) exp_q.push_back(d);
      tick();
   endtask

   task automatic wait_drain(input int lim);
      int n = 0;
      while ((exp_q.size() != 0 || bus.tx_busy || !bus.empty) && n < lim) begin
         tick();
         n++;
      end
      chk("drain_timeout", (n >= lim), 0);
      tick();
      tick();
   endtask

   task automatic wait_brk(input int lim);
      int n = 0;
      while (!bus.tx_break && n < lim) begin
         tick();
         n++;
      end
      chk("break_start_timeout", (n >= lim), 0);
   endtask

   // Monitor: every start strobe must match the head of the scoreboard.
   initial begin
      logic       prev_busy  = 1'b0;
      logic       prev_valid = 1'b0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (reset && bus.tx_valid) begin
            tx_cnt++;
            chk("launch_after_busy_low", prev_busy, 0);
            chk("tx_valid_one_cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected: got %0h expected none", bus.tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("tx_data", bus.tx_data, e);
            end
         end
         prev_busy  = bus.tx_busy;
         prev_valid = bus.tx_valid;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int c0, len;
      reset        = 1'b0;
      hold_busy    = 1'b0;
      bus.wrdata   = '0;
      bus.wr_en    = 1'b0;
      bus.flush    = 1'b0;
      bus.brk_req  = 1'b0;
      bus.uart_cts = 1'b0;
      tick();
      tick();
      chk("rst_full", bus.full, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_free", bus.free_count, 16);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_brk_active", bus.brk_active, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_tx_break", bus.tx_break, 0);
      reset = 1'b1;
      tick();

      // Three bytes in order.
      wr(8'h41, 1); wr(8'h42, 1); wr(8'h43, 1);
      bus.wr_en = 1'b0;
      wait_drain(200);
      chk("t1_empty", bus.empty, 1);
      chk("t1_free", bus.free_count, 16);

      // Write-to-launch latency from an empty, idle queue.
      wr(8'h5A, 1);
      bus.wr_en = 1'b0;
      chk("lat_n", bus.tx_valid, 0);
      tick();
      chk("lat_n1_valid", bus.tx_valid, 1);
      chk("lat_n1_data", bus.tx_data, 8'h5A);
      wait_drain(100);

      // Fill with the UART held busy: 16 accepted, 17th overflows.
      hold_busy = 1'b1;
      c0 = tx_cnt;
      for (int i = 0; i < 17; i++) begin
         wr(8'(i), i < 16);
         if (i == 15) begin
            chk("fill_full", bus.full, 1);
            chk("fill_free", bus.free_count, 0);
            chk("fill_no_ovf", bus.overflow, 0);
         end
      end
      bus.wr_en = 1'b0;
      chk("ovf_pulse", bus.overflow, 1);
      tick();
      chk("ovf_one_cycle", bus.overflow, 0);
      chk("fill_still_full", bus.full, 1);
      tick();
      tick();
      chk("fill_no_tx", tx_cnt - c0, 0);
      hold_busy = 1'b0;
      tick();
      chk("release_launch", bus.tx_valid, 1);
      wait_drain(16 * (FRAME + 6) + 50);
      chk("fill_drained_cnt", tx_cnt - c0, 16);

`ifdef ESP_TXQ_CTS_EN
      // CTS gating: blocked while high, launches 3 cycles after release.
      bus.uart_cts = 1'b1;
      tick(); tick(); tick();
      c0 = tx_cnt;
      wr(8'h77, 1);
      bus.wr_en = 1'b0;
      tick(); tick(); tick();
      chk("cts_blocked", tx_cnt - c0, 0);
      bus.uart_cts = 1'b0;
      tick();
      chk("cts_k0", bus.tx_valid, 0);
      tick();
      chk("cts_k1", bus.tx_valid, 0);
      tick();
      chk("cts_k2", bus.tx_valid, 1);
      wr(8'h78, 1);
      bus.wr_en    = 1'b0;
      bus.uart_cts = 1'b1;
      for (int i = 0; i < FRAME + 10; i++) tick();
      chk("cts_midbyte", tx_cnt - c0, 1);
      bus.uart_cts = 1'b0;
      wait_drain(100);
      chk("cts_resume", tx_cnt - c0, 2);
`endif

      // Two bytes then a break request.
      c0 = tx_cnt;
      wr(8'hA1, 1); wr(8'hA2, 1);
      bus.wr_en   = 1'b0;
      bus.brk_req = 1'b1;
      tick();
      bus.brk_req = 1'b0;
      chk("brk_active_set", bus.brk_active, 1);
      chk("brk_not_early", bus.tx_break, 0);
      wait_brk(200);
      chk("brk_after_bytes", tx_cnt - c0, 2);
      chk("brk_q_empty", exp_q.size(), 0);
      len = 0;
      while (bus.tx_break && len < BC + 20) begin
         tick();
         len++;
      end
      chk("brk_len", len, BC);
      chk("brk_active_clear", bus.brk_active, 0);
      tick();

      // Flush with 5 queued and one in flight; same-cycle write dropped silently.
      c0 = tx_cnt;
      wr(8'hB0, 1);
      for (int i = 1; i < 6; i++) wr(8'(8'hB0 + i), 0);
      chk("flush_pre_free", bus.free_count, 11);
      bus.flush  = 1'b1;
      bus.wrdata = 8'hEE;
      bus.wr_en  = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      chk("flush_empty", bus.empty, 1);
      chk("flush_no_ovf", bus.overflow, 0);
      chk("flush_free", bus.free_count, 16);
      wait_drain(100);
      chk("flush_inflight", tx_cnt - c0, 1);

      // Reset in the middle of a break.
      bus.brk_req = 1'b1;
      tick();
      bus.brk_req = 1'b0;
      wait_brk(50);
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_brk_tx_break", bus.tx_break, 0);
      chk("rst_brk_active", bus.brk_active, 0);
      reset = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
